// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin owner selection for the shared ULA datapath.
// One requester at a time receives a grant, the ULA gets a one-cycle start
// pulse, and the grant is held until done or until the WAIT timeout expires.
// The priority pointer moves to (owner+1) mod 4 on every release, which keeps
// the four requesters fair.
module ula_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       alu_start,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Counter value on the last permitted WAIT cycle.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  idx_q, idx_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [1:0]  winner_s;

  // First set request bit scanning upward from the pointer, modulo 4.
  // The loop runs downward so that the lowest offset is assigned last and wins.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] win;
    logic [1:0] k;
    win = p;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) begin
        win = k;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  assign winner_s = pick_winner(req, ptr_q);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          state_d = S_START;
          grant_d = 4'b0001 << winner_s;
          idx_d   = winner_s;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          grant_d = 4'b0000;
          idx_d   = 2'd0;
          busy_d  = 1'b0;
        end
      end
      S_START: begin
        // done is deliberately ignored while the ULA is being started.
        state_d = S_WAIT;
        cnt_d   = {TW{1'b0}};
      end
      S_WAIT: begin
        // done has priority over the timeout when both occur together.
        if (done) begin
          state_d = S_RELEASE;
          grant_d = 4'b0000;
          ptr_d   = idx_q + 2'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASE;
          grant_d = 4'b0000;
          ptr_d   = idx_q + 2'd1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_RELEASE: begin
        // grant_idx stayed on the last owner during the dead cycle; IDLE shows zeros.
        state_d = S_IDLE;
        grant_d = 4'b0000;
        idx_d   = 2'd0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        idx_d   = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= {TW{1'b0}};
      grant_q <= 4'b0000;
      idx_q   <= 2'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign alu_start   = start_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
